// File: rtl/sync_fifo_model.sv
// ----------------------------------------------------------------------------
// sync_fifo_model
//   Cycle-accurate behavioural model of a single-clock block-RAM FIFO used by
//   the NAND-channel data buffers. It has programmable almost-full and
//   almost-empty flags, and it pulses wr_err/rd_err for one cycle on each
//   rejected request.
//
//   Optional feature: define SYNC_FIFO_MODEL_FWFT_EN to build the
//   first-word-fall-through variant. In that variant a prefetch register
//   presents the head word on dout without a request, and rd_en acts as the
//   acknowledge. When the macro is not defined, a read returns its data one
//   clock after it is accepted.
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   wr_en / din   write request and data
//   rd_en         read request (acknowledge in FWFT mode)
//   dout          read data
//   dout_valid    dout holds a freshly read/presented word
//   empty, full, almost_empty, almost_full   registered status flags
//   count         words stored (includes the prefetched word in FWFT mode)
//   wr_err        one-cycle pulse: write attempted while full
//   rd_err        one-cycle pulse: read attempted while empty
// ----------------------------------------------------------------------------
module sync_fifo_model #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned DEPTH_LOG2    = 9,
    parameter int unsigned AFULL_OFFSET  = 16,
    parameter int unsigned AEMPTY_OFFSET = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(DEPTH - AFULL_OFFSET);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_OFFSET);

    if (AFULL_OFFSET >= DEPTH || AEMPTY_OFFSET >= DEPTH) begin : g_param_check
        $fatal(1, "sync_fifo_model: AFULL_OFFSET and AEMPTY_OFFSET must be below DEPTH");
    end

    // Storage is deliberately not reset; a reset only rewinds the pointers.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dv_q, dv_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  aempty_q, aempty_d;
    logic                  afull_q, afull_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_err_q, rd_err_d;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;
`ifdef SYNC_FIFO_MODEL_FWFT_EN
    logic [CW-1:0]         mem_cnt;
`endif

    always_comb begin
        wr_acc   = wr_en && !full_q;
`ifdef SYNC_FIFO_MODEL_FWFT_EN
        rd_acc   = rd_en && dv_q;
`else
        rd_acc   = rd_en && !empty_q;
`endif
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;
        mem_we   = wr_acc;

`ifdef SYNC_FIFO_MODEL_FWFT_EN
        // The prefetch register counts as stored, so only the remaining words
        // are in the RAM. If the RAM is empty while the register frees up, a
        // word that is being written bypasses the RAM. This lets the word
        // appear on dout one cycle after its write edge.
        mem_cnt = count_q - CW'(dv_q);
        dv_d    = dv_q && !rd_acc;
        if (!dv_q || rd_acc) begin
            if (mem_cnt != '0) begin
                dout_d   = mem[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PW'(1);
                dv_d     = 1'b1;
            end else if (wr_acc) begin
                dout_d = din;
                dv_d   = 1'b1;
                mem_we = 1'b0;
            end
        end
        empty_d = !dv_d;
`else
        if (rd_acc) begin
            dout_d   = mem[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
            dv_d     = 1'b1;
        end
        empty_d = (count_d == '0);
`endif

        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        full_d   = (count_d == DEPTH_C);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
        wr_err_d = wr_en && full_q;
        rd_err_d = rd_en && empty_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dv_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = aempty_q;
    assign almost_full  = afull_q;
    assign count        = count_q;
    assign wr_err       = wr_err_q;
    assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_model.sv
module tb_sync_fifo_model;

    localparam int unsigned DW    = 8;
    localparam int unsigned DL    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFO   = 2;
    localparam int unsigned AEO   = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] din   = '0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [DL:0]   count;
    logic          wr_err;
    logic          rd_err;

    sync_fifo_model #(
        .DATA_WIDTH   (DW),
        .DEPTH_LOG2   (DL),
        .AFULL_OFFSET (AFO),
        .AEMPTY_OFFSET(AEO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .count       (count),
        .wr_err      (wr_err),
        .rd_err      (rd_err)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of stored words plus the last read word.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_dv   = 1'b0;
    bit            m_werr = 1'b0;
    bit            m_rerr = 1'b0;

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_werr = 1'b0;
        m_rerr = 1'b0;
    endtask

    task automatic cmp_model(input string tag);
        int unsigned n;
        n = mq.size();
        check({tag, ".count"},        32'(count),        n);
        check({tag, ".dout"},         32'(dout),         32'(m_dout));
        check({tag, ".dout_valid"},   32'(dout_valid),   32'(m_dv));
        check({tag, ".empty"},        32'(empty),        32'(n == 0));
        check({tag, ".full"},         32'(full),         32'(n == DEPTH));
        check({tag, ".almost_full"},  32'(almost_full),  32'(n >= DEPTH - AFO));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AEO));
        check({tag, ".wr_err"},       32'(wr_err),       32'(m_werr));
        check({tag, ".rd_err"},       32'(rd_err),       32'(m_rerr));
    endtask

    // One clock: drive, advance the model from the pre-edge occupancy, compare.
    task automatic cyc(input string tag, input bit w, input bit r, input logic [DW-1:0] d);
        bit full_pre;
        bit empty_pre;
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        full_pre  = (mq.size() == DEPTH);
        empty_pre = (mq.size() == 0);
        m_werr    = w && full_pre;
        m_rerr    = r && empty_pre;
        m_dv      = r && !empty_pre;
        if (m_dv) m_dout = mq.pop_front();
        if (w && !full_pre) mq.push_back(d);
        #1;
        cmp_model(tag);
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [7:0]  din;
        logic [4:0]  cnt;
        bit          werr;
        bit          rerr;
        bit          dv;
        logic [7:0]  dout;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b1, 8'h11};
        tbl[3] = '{1'b1, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b1, 8'h22};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 8'h33};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 8'h33};
        tbl[6] = '{1'b1, 1'b1, 8'h44, 5'd1, 1'b0, 1'b1, 1'b0, 8'h33};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 8'h44};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.count",        32'(count),        0);
        check("rst.dout",         32'(dout),         0);
        check("rst.dout_valid",   32'(dout_valid),   0);
        check("rst.empty",        32'(empty),        1);
        check("rst.full",         32'(full),         0);
        check("rst.almost_empty", 32'(almost_empty), 1);
        check("rst.almost_full",  32'(almost_full),  0);
        check("rst.wr_err",       32'(wr_err),       0);
        check("rst.rd_err",       32'(rd_err),       0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SYNC_FIFO_MODEL_FWFT_EN
        wr_en = 1'b1; din = 8'h5A;
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("fwft.dout",       32'(dout),       32'h5A);
        check("fwft.dout_valid", 32'(dout_valid), 1);
        check("fwft.empty",      32'(empty),      0);
        check("fwft.count",      32'(count),      1);
        @(posedge clk); #1;
        check("fwft.hold_dout",  32'(dout),       32'h5A);
        check("fwft.hold_valid", 32'(dout_valid), 1);
        rd_en = 1'b1;
        @(posedge clk); #1;
        check("fwft.ack_valid",  32'(dout_valid), 0);
        check("fwft.ack_empty",  32'(empty),      1);
        check("fwft.ack_count",  32'(count),      0);
        @(posedge clk); #1;
        rd_en = 1'b0;
        check("fwft.rd_err",     32'(rd_err),     1);
        @(posedge clk); #1;
        check("fwft.rd_err_clr", 32'(rd_err),     0);
`else
        // Table of short boundary vectors, expectations written by hand.
        for (int i = 0; i < 8; i++) begin
            cyc("tbl", tbl[i].wr, tbl[i].rd, tbl[i].din);
            check($sformatf("tbl%0d.count", i),  32'(count),      32'(tbl[i].cnt));
            check($sformatf("tbl%0d.wr_err", i), 32'(wr_err),     32'(tbl[i].werr));
            check($sformatf("tbl%0d.rd_err", i), 32'(rd_err),     32'(tbl[i].rerr));
            check($sformatf("tbl%0d.dv", i),     32'(dout_valid), 32'(tbl[i].dv));
            check($sformatf("tbl%0d.dout", i),   32'(dout),       32'(tbl[i].dout));
        end

        // Reset asserted between clock edges in the middle of a burst.
        cyc("burst", 1'b1, 1'b0, 8'h61);
        cyc("burst", 1'b1, 1'b0, 8'h62);
        cyc("burst", 1'b0, 1'b1, 8'h00);
        wr_en = 1'b1; din = 8'h63;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.empty",      32'(empty),      1);
        check("arst.count",      32'(count),      0);
        check("arst.dout",       32'(dout),       0);
        check("arst.dout_valid", 32'(dout_valid), 0);
        @(posedge clk); #1;
        cmp_model("arst_hold");
        #2;
        rst_n = 1'b1;
        cyc("post_rst_rd", 1'b0, 1'b1, 8'h00);
        check("post_rst.rd_err", 32'(rd_err), 1);
        cyc("post_rst_idle", 1'b0, 1'b0, 8'h00);
        check("post_rst.rd_err_clr", 32'(rd_err), 0);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) begin
            cyc("fill", 1'b1, 1'b0, 8'(i));
            if (i == 12) check("fill.af_at13", 32'(almost_full), 0);
            if (i == 13) check("fill.af_at14", 32'(almost_full), 1);
            if (i == 14) check("fill.full_at15", 32'(full), 0);
            if (i == 15) check("fill.full_at16", 32'(full), 1);
        end
        cyc("ovf", 1'b1, 1'b0, 8'hAA);
        check("ovf.wr_err", 32'(wr_err), 1);
        check("ovf.count",  32'(count),  16);
        cyc("ovf_idle", 1'b0, 1'b0, 8'h00);
        check("ovf.wr_err_clr", 32'(wr_err), 0);

        // Drain from full; data must come back 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            cyc("drain", 1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d.dout", i), 32'(dout),       32'(i));
            check($sformatf("drain%0d.dv", i),   32'(dout_valid), 1);
            if (i == 12) check("drain.ae_at3", 32'(almost_empty), 0);
            if (i == 13) check("drain.ae_at2", 32'(almost_empty), 1);
            if (i == 15) check("drain.empty",  32'(empty),        1);
        end

        // Empty with both requests: write wins, read flagged.
        cyc("empty_rw", 1'b1, 1'b1, 8'h77);
        check("empty_rw.count",  32'(count),      1);
        check("empty_rw.rd_err", 32'(rd_err),     1);
        check("empty_rw.dv",     32'(dout_valid), 0);

        // Full with both requests: read wins, write flagged.
        for (int i = 0; i < 15; i++) cyc("refill", 1'b1, 1'b0, 8'(8'h80 + i));
        check("refill.full", 32'(full), 1);
        cyc("full_rw", 1'b1, 1'b1, 8'h99);
        check("full_rw.count",  32'(count),  15);
        check("full_rw.wr_err", 32'(wr_err), 1);
        check("full_rw.dout",   32'(dout),   32'h77);

        // Wrap-around at constant occupancy 5.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("wrap_rst.count", 32'(count), 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc("wrap_pre", 1'b1, 1'b0, 8'(i));
        for (int k = 0; k < 40; k++) begin
            cyc("wrap", 1'b1, 1'b1, 8'(5 + k));
            check($sformatf("wrap%0d.dout", k),  32'(dout),  32'(k));
            check($sformatf("wrap%0d.count", k), 32'(count), 5);
        end

        // Random traffic in phases biased toward full, toward empty, then even.
        for (int ph = 0; ph < 3; ph++) begin
            int unsigned wp;
            int unsigned rp;
            wp = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
            rp = (ph == 0) ? 30 : (ph == 1) ? 85 : 50;
            for (int k = 0; k < 150; k++) begin
                cyc("rand", $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
            end
        end
`endif

        wr_en = 1'b0;
        rd_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_fifo_model.md
Name: sync_fifo_model

Overview:
- Behavioural simulation model of a single-clock block-RAM FIFO primitive.
- Lives alongside the constant tie-off primitive models.
- Is a direct consumer of those tie-off constants: unused write/read enables of instances in the NAND-channel datapath models are tied through the ground model.
- Gives the channel data buffers a cycle-accurate FIFO with programmable almost-full/almost-empty flags and sticky-free error pulses, so the buffers can simulate without vendor libraries.

Parameters:
- DATA_WIDTH, 64, width of din/dout.
- DEPTH_LOG2, 9, log2 of storage depth (DEPTH = 2**DEPTH_LOG2 = 512).
- AFULL_OFFSET, 16, almost_full asserted when count >= DEPTH - AFULL_OFFSET.
- AEMPTY_OFFSET, 16, almost_empty asserted when count <= AEMPTY_OFFSET.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- din  input  DATA_WIDTH  write data.
- rd_en  input  1  read request (acknowledge in FWFT mode).
- dout  output  DATA_WIDTH  read data.
- dout_valid  output  1  dout holds a freshly read/presented word.
- empty  output  1  no readable word.
- full  output  1  DEPTH words stored.
- almost_empty  output  1  programmable low-water flag.
- almost_full  output  1  programmable high-water flag.
- count  output  DEPTH_LOG2+1  words stored.
- wr_err  output  1  one-cycle pulse: write attempted while full.
- rd_err  output  1  one-cycle pulse: read attempted while empty.

Behaviour:
- Reset:
  - Clock and reset: one clock, clk; reset is rst_n, asynchronous, active-low. Assertion takes effect immediately, independent of clk.
  - On reset: wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, wr_err=0, rd_err=0.
  - Memory contents are not cleared; reset mid-operation discards all stored words.
- Write accept:
  - Write accepted iff wr_en && !full, with full sampled as the pre-edge registered value.
  - On accept: mem[wr_ptr]<=din; wr_ptr increments modulo DEPTH (natural DEPTH_LOG2-bit wrap).
- Read accept (standard mode):
  - Read accepted iff rd_en && !empty, pre-edge value.
  - On accept: dout<=mem[rd_ptr]; rd_ptr increments modulo DEPTH. Latency is 1 clock.
  - dout_valid = 1 in the cycle after an accepted read, else 0. dout holds its value when no read is accepted.
- Count:
  - count_next = count + accepted_write - accepted_read.
  - Never exceeds DEPTH and never underflows.
- Simultaneous events:
  - full with wr_en&&rd_en: read accepted, write rejected, wr_err pulses.
  - empty with wr_en&&rd_en: write accepted, read rejected, rd_err pulses.
  - Neither full nor empty: both accepted, count unchanged.
- Flags:
  - All flags are registered and computed from count_next, so they are valid the cycle after the causing edge.
  - empty = (count_next==0).
  - full = (count_next==DEPTH).
  - almost_full = (count_next >= DEPTH-AFULL_OFFSET).
  - almost_empty = (count_next <= AEMPTY_OFFSET).
- Error pulses: wr_err/rd_err are registered, asserted exactly one cycle per offending request, and never sticky.
- Parameter check: an elaboration check fails if AFULL_OFFSET or AEMPTY_OFFSET is >= DEPTH.

Optional Feature:
- Macro: SYNC_FIFO_MODEL_FWFT_EN.
- Defined (first-word-fall-through):
  - An output prefetch register presents the head word on dout with dout_valid=1 without a request.
  - A word written into an empty FIFO appears on dout with dout_valid=1 one cycle after the write edge.
  - rd_en acts as acknowledge: accepted iff rd_en && dout_valid. The next word, if any, is presented in the following cycle.
  - empty = !dout_valid.
  - count includes the prefetched word.
  - rd_err pulses on rd_en while dout_valid=0.
- Undefined: standard-mode behaviour above, 1-cycle read latency.

Test Plan (DEPTH_LOG2=4, DEPTH=16, AFULL_OFFSET=2, AEMPTY_OFFSET=2, DATA_WIDTH=8):
- Reset and flags: assert rst_n=0 mid-burst between clock edges.
  - Outputs go to reset values immediately: empty=1, count=0, dout=0.
  - After release, a read gives rd_err=1 for one cycle.
- Fill to full: write 0x00..0x0F on 16 consecutive cycles.
  - almost_full rises after the 14th write (count=14).
  - full=1 after the 16th write.
  - A 17th write of 0xAA gives wr_err=1, count stays 16, and 0xAA is never read back.
- Drain: read 16 consecutive cycles from full.
  - dout = 0x00..0x0F, each one cycle after its rd_en, with dout_valid=1.
  - almost_empty rises when count=2; empty=1 after the last read.
- Simultaneous read/write at the boundaries:
  - Full with wr_en=rd_en=1: count 16->15, wr_err=1.
  - Empty with both asserted: count 0->1, rd_err=1, no dout_valid.
- Wrap-around: keep occupancy at 5 while streaming 40 words with concurrent read/write.
  - Pointers wrap at least twice; output order exactly matches input order; count stays 5.
- FWFT build: write 0x5A into empty FIFO.
  - dout=0x5A with dout_valid=1 next cycle, without rd_en.
  - rd_en acknowledge gives dout_valid=0 and empty=1.
